// File: rtl/keypad_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : keypad_operand_loader
// Description : Consumer side of the keypad scanner handshake. Strobes KeyRd,
//               captures two assembled words as operands A and B, and offers
//               the pair to the MAC datapath with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_operand_loader #(
    parameter int OP_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             PB2,
    input  logic             KeyEn,
    input  logic             Clr,
    input  logic             data_ready,
    input  logic [OP_W-1:0]  mem_reg,
    input  logic             op_ready,
    output logic             KeyRd,
    output logic [OP_W-1:0]  op_a,
    output logic [OP_W-1:0]  op_b,
    output logic             op_valid,
    output logic [CNT_W-1:0] pair_cnt,
    output logic [3:0]       led
);

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'b001,
        S_GAP_A   = 3'b010,
        S_WAIT_B  = 3'b011,
        S_PRESENT = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic             r_dr_q;
    logic             r_keyrd;
    logic [OP_W-1:0]  r_op_a;
    logic [OP_W-1:0]  r_op_b;
    logic             r_op_valid;
    logic [CNT_W-1:0] r_pair_cnt;
    logic [2:0]       r_led_code;

    logic             w_dr_rise;
    logic             w_keyrd_next;
    logic [OP_W-1:0]  w_op_a_next;
    logic [OP_W-1:0]  w_op_b_next;
    logic             w_op_valid_next;
    logic [CNT_W-1:0] w_pair_cnt_next;

    assign w_dr_rise = data_ready & ~r_dr_q;

    // Next-state and next-output decode; Clr overrides every state.
    always_comb begin
        w_state_next    = r_state;
        w_keyrd_next    = 1'b0;
        w_op_a_next     = r_op_a;
        w_op_b_next     = r_op_b;
        w_op_valid_next = r_op_valid;
        w_pair_cnt_next = r_pair_cnt;

        if (Clr) begin
            w_state_next    = S_WAIT_A;
            w_op_valid_next = 1'b0;
        end else begin
            case (r_state)
                S_WAIT_A: begin
                    w_keyrd_next = KeyEn;
                    if (w_dr_rise) begin
                        w_op_a_next  = mem_reg;
                        w_keyrd_next = 1'b0;
                        w_state_next = S_GAP_A;
                    end
                end
                S_GAP_A: begin
                    // The capture edge already dropped KeyRd; re-arming it on
                    // the way out keeps the deassertion to exactly one cycle.
                    w_keyrd_next = KeyEn;
                    w_state_next = S_WAIT_B;
                end
                S_WAIT_B: begin
                    w_keyrd_next = KeyEn;
                    if (w_dr_rise) begin
                        w_op_b_next     = mem_reg;
                        w_keyrd_next    = 1'b0;
                        w_op_valid_next = 1'b1;
                        w_state_next    = S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (r_op_valid && op_ready) begin
                        w_op_valid_next = 1'b0;
                        w_pair_cnt_next = r_pair_cnt + c_CNT_ONE;
                        w_state_next    = S_WAIT_A;
                    end
                end
                default: begin
                    w_state_next    = S_WAIT_A;
                    w_op_valid_next = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!PB2) begin
            r_state    <= S_WAIT_A;
            r_dr_q     <= 1'b1;
            r_keyrd    <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_valid <= 1'b0;
            r_pair_cnt <= '0;
            r_led_code <= 3'b000;
        end else begin
            r_state    <= w_state_next;
            r_dr_q     <= data_ready;
            r_keyrd    <= w_keyrd_next;
            r_op_a     <= w_op_a_next;
            r_op_b     <= w_op_b_next;
            r_op_valid <= w_op_valid_next;
            r_pair_cnt <= w_pair_cnt_next;
            // LED state field reads dark while in reset and for the cycle
            // right after it, then tracks the live state code.
            r_led_code <= w_state_next;
        end
    end

    assign KeyRd    = r_keyrd;
    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign op_valid = r_op_valid;
    assign pair_cnt = r_pair_cnt;
    assign led      = {r_op_valid, r_led_code};

endmodule
`default_nettype wire
